// File: rtl/ula_multiciclo.sv
// ---------------------------------------------------------------------------
// ula_multiciclo
//
// Multi-cycle ALU that takes the 4-bit ALUControl code from the ALU-control
// decoder. Logic and arithmetic operations finish one cycle after they are
// accepted. Shifts by a non-zero amount run one bit per cycle, so the control
// unit can stall on busy while a long shift is in progress.
//
// Ports
//   clk        in   1      clock, every state update on the rising edge
//   rst_n      in   1      synchronous reset, active-low
//   start      in   1      launch an operation (only looked at in IDLE)
//   alu_ctrl   in   4      ALUControl code
//   a          in   WIDTH  operand A (rs)
//   b          in   WIDTH  operand B (rt / immediate), also the shift source
//   shamt      in   SHW    shift amount for SLL/SRL/SRA
//   busy       out  1      high whenever the FSM is not in IDLE
//   done       out  1      one-cycle pulse; result and flags are valid
//   result     out  WIDTH  registered result, held until the next accepted op
//   zero       out  1      result == 0 (for BNE: a != b)
//   overflow   out  1      signed overflow of ADD/SUB, 0 otherwise
//   illegal    out  1      alu_ctrl was not a recognised code
//   dbg_state  out  2      current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
//
// Handshake: an operation is accepted on a rising edge where the FSM is in
// IDLE and start is high; a, b, alu_ctrl and shamt are captured on that edge
// and are not looked at again for that operation. start is ignored while busy.
// done is high for exactly one cycle, and result/flags are stable from that
// cycle until the next accepted operation.
// ---------------------------------------------------------------------------
module ula_multiciclo #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [1:0]       dbg_state
);

  // ALUControl codes
  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SLLV = 4'b0011;
  localparam logic [3:0] C_SRLV = 4'b0100;
  localparam logic [3:0] C_SRAV = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_BNE  = 4'b1000;
  localparam logic [3:0] C_SLL  = 4'b1001;
  localparam logic [3:0] C_SRL  = 4'b1010;
  localparam logic [3:0] C_XOR  = 4'b1011;
  localparam logic [3:0] C_NOR  = 4'b1100;
  localparam logic [3:0] C_SRA  = 4'b1101;
  localparam logic [3:0] C_SLTU = 4'b1111;

  // Shift direction/fill kept across the iterative shift
  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;
  logic             r_illegal;
  logic [WIDTH-1:0] r_shreg;
  logic [SHW-1:0]   r_cnt;
  logic [1:0]       r_kind;

  // Decode of the operation presented on the inputs
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_zero;
  logic             w_ovf;
  logic             w_illegal;
  logic             w_is_bne;
  logic             w_is_shift;
  logic [1:0]       w_kind;
  logic [SHW-1:0]   w_amt;

  // Iterative shift step and FSM control
  logic [WIDTH-1:0] w_shift_step;
  logic             w_accept;
  logic             w_start_shift;
  logic             w_last_shift;

  assign w_sum  = a + b;
  assign w_diff = a - b;

  always_comb begin
    w_res      = '0;
    w_ovf      = 1'b0;
    w_illegal  = 1'b0;
    w_is_bne   = 1'b0;
    w_is_shift = 1'b0;
    w_kind     = K_SLL;
    w_amt      = shamt;
    case (alu_ctrl)
      C_AND:  w_res = a & b;
      C_OR:   w_res = a | b;
      C_XOR:  w_res = a ^ b;
      C_NOR:  w_res = ~(a | b);
      C_ADD: begin
        w_res = w_sum;
        // Same-sign operands whose sum changes sign
        w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      C_SUB: begin
        w_res = w_diff;
        // Different-sign operands whose difference takes b's sign
        w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      C_SLT:  w_res[0] = ($signed(a) < $signed(b));
      C_SLTU: w_res[0] = (a < b);
      C_BNE: begin
        w_res    = w_diff;
        w_is_bne = 1'b1;
      end
      // Shifts: w_res = b covers the zero-amount case, which completes
      // in one cycle with b unchanged.
      C_SLL: begin
        w_is_shift = 1'b1;
        w_kind     = K_SLL;
        w_res      = b;
      end
      C_SRL: begin
        w_is_shift = 1'b1;
        w_kind     = K_SRL;
        w_res      = b;
      end
      C_SRA: begin
        w_is_shift = 1'b1;
        w_kind     = K_SRA;
        w_res      = b;
      end
      C_SLLV: begin
        w_is_shift = 1'b1;
        w_kind     = K_SLL;
        w_amt      = a[SHW-1:0];
        w_res      = b;
      end
      C_SRLV: begin
        w_is_shift = 1'b1;
        w_kind     = K_SRL;
        w_amt      = a[SHW-1:0];
        w_res      = b;
      end
      C_SRAV: begin
        w_is_shift = 1'b1;
        w_kind     = K_SRA;
        w_amt      = a[SHW-1:0];
        w_res      = b;
      end
      default: begin
        w_res     = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  // BNE reports "branch taken" on zero rather than the subtraction result
  assign w_zero = w_is_bne ? (a != b) : (w_res == '0);

  always_comb begin
    w_shift_step = r_shreg;
    case (r_kind)
      K_SLL:   w_shift_step = {r_shreg[WIDTH-2:0], 1'b0};
      K_SRL:   w_shift_step = {1'b0, r_shreg[WIDTH-1:1]};
      K_SRA:   w_shift_step = {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
      default: w_shift_step = r_shreg;
    endcase
  end

  assign w_accept      = (r_state == S_IDLE) && start;
  assign w_start_shift = w_is_shift && (w_amt != '0);
  assign w_last_shift  = (r_state == S_SHIFT) && (r_cnt == SHW'(1));

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = w_start_shift ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == SHW'(1)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_kind     <= K_SLL;
    end else begin
      r_state <= w_next_state;

      if (w_accept) begin
        if (w_start_shift) begin
          // Result and flags stay at the previous op's values until the
          // last shift step lands.
          r_shreg <= b;
          r_cnt   <= w_amt;
          r_kind  <= w_kind;
        end else begin
          r_result   <= w_res;
          r_zero     <= w_zero;
          r_overflow <= w_ovf;
          r_illegal  <= w_illegal;
        end
      end

      if (r_state == S_SHIFT) begin
        r_shreg <= w_shift_step;
        r_cnt   <= r_cnt - SHW'(1);
      end

      if (w_last_shift) begin
        r_result   <= w_shift_step;
        r_zero     <= (w_shift_step == '0);
        r_overflow <= 1'b0;
        r_illegal  <= 1'b0;
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign illegal   = r_illegal;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ula_multiciclo.sv
// ---------------------------------------------------------------------------
// tb_ula_multiciclo
//
// Directed cases for the documented corner behaviour followed by randomized
// operations. Expected results, flags and completion latency come from a
// plain-arithmetic model of the ALU; completed results go through exp_q.
// ---------------------------------------------------------------------------
module tb_ula_multiciclo;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  // clock / reset
  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  ula_multiciclo #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .alu_ctrl  (alu_ctrl),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // scoreboard
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: what the ALU should report for one operation and how
  // many rising edges (counting the accepting one) until done is seen.
  task automatic model(input logic [3:0] c, input logic [31:0] va,
                       input logic [31:0] vb, input logic [4:0] sh,
                       output logic [31:0] res, output logic z,
                       output logic ov, output logic il, output int lat);
    longint sa, sb, wide;
    int     amt;
    bit     is_shift;
    sa       = longint'($signed(va));
    sb       = longint'($signed(vb));
    res      = 32'd0;
    ov       = 1'b0;
    il       = 1'b0;
    is_shift = 1'b0;
    amt      = 0;
    case (c)
      4'b0000: res = va & vb;
      4'b0001: res = va | vb;
      4'b1011: res = va ^ vb;
      4'b1100: res = ~(va | vb);
      4'b0010: begin
        wide = sa + sb;
        res  = va + vb;
        ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0110: begin
        wide = sa - sb;
        res  = va - vb;
        ov   = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'b0111: res = (sa < sb) ? 32'd1 : 32'd0;
      4'b1111: res = (va < vb) ? 32'd1 : 32'd0;
      4'b1000: res = va - vb;
      4'b1001: begin is_shift = 1; amt = int'(sh);      res = vb << amt; end
      4'b1010: begin is_shift = 1; amt = int'(sh);      res = vb >> amt; end
      4'b1101: begin is_shift = 1; amt = int'(sh);      res = $signed(vb) >>> amt; end
      4'b0011: begin is_shift = 1; amt = int'(va[4:0]); res = vb << amt; end
      4'b0100: begin is_shift = 1; amt = int'(va[4:0]); res = vb >> amt; end
      4'b0101: begin is_shift = 1; amt = int'(va[4:0]); res = $signed(vb) >>> amt; end
      default: begin res = 32'd0; il = 1'b1; end
    endcase
    z   = (c == 4'b1000) ? (va != vb) : (res == 32'd0);
    lat = (is_shift && amt > 0) ? amt + 1 : 1;
  endtask

  // driver: one operation, optionally hammering start while it is busy
  task automatic run_op(input logic [3:0] c, input logic [31:0] va,
                        input logic [31:0] vb, input logic [4:0] sh,
                        input bit spam);
    logic [31:0] e_res;
    logic        e_z, e_ov, e_il;
    int          e_lat;
    int          cyc;
    model(c, va, vb, sh, e_res, e_z, e_ov, e_il, e_lat);
    exp_q.push_back(e_res);

    @(negedge clk);
    start    = 1'b1;
    alu_ctrl = c;
    a        = va;
    b        = vb;
    shamt    = sh;
    @(posedge clk);
    #1;
    cyc = 1;
    // Operands were captured; scramble them to prove they no longer matter
    start    = spam;
    alu_ctrl = spam ? 4'b0010 : 4'($urandom);
    a        = $urandom;
    b        = $urandom;
    shamt    = 5'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      a = $urandom;
      b = $urandom;
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'(e_lat));
    check("result", result, exp_q.pop_front());
    check("zero", 32'(zero), 32'(e_z));
    check("overflow", 32'(overflow), 32'(e_ov));
    check("illegal", 32'(illegal), 32'(e_il));
    @(posedge clk);
    #1;
    check("done_pulse_1cyc", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("result_held", result, e_res);
  endtask

  logic [3:0] codes[16];
  logic [31:0] rv;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b1;
    alu_ctrl = 4'b0010;
    a        = 32'd1;
    b        = 32'd2;
    shamt    = 5'd0;

    // Reset wins over start
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, zero, overflow, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;

    // Directed cases
    run_op(4'b0010, 32'd7, 32'd5, 5'd0, 1'b0);                // ADD
    run_op(4'b0110, 32'h8000_0000, 32'd1, 5'd0, 1'b0);        // SUB ovf
    run_op(4'b1000, 32'd9, 32'd9, 5'd0, 1'b0);                // BNE equal
    run_op(4'b1000, 32'd9, 32'd4, 5'd0, 1'b0);                // BNE differ
    run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0);        // ADD ovf
    run_op(4'b1101, 32'd0, 32'hF000_0000, 5'd4, 1'b0);        // SRA 4
    run_op(4'b0100, 32'd0, 32'hDEAD_BEEF, 5'd0, 1'b0);        // SRLV by 0
    run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);        // SLT
    run_op(4'b1111, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);        // SLTU
    run_op(4'b1110, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 1'b0);// illegal
    run_op(4'b1001, 32'd0, 32'd1, 5'd31, 1'b1);               // SLL 31, start spam

    // SRL 20 aborted by reset mid-shift
    @(negedge clk);
    start    = 1'b1;
    alu_ctrl = 4'b1010;
    a        = 32'd0;
    b        = 32'hFFFF_0000;
    shamt    = 5'd20;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("shift_no_early_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_flags", {29'd0, zero, overflow, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_stays_idle", 32'({busy, done}), 32'd0);
    run_op(4'b0010, 32'd100, 32'd23, 5'd0, 1'b0);

    // Randomized operations over every code
    for (int i = 0; i < 16; i++) codes[i] = 4'(i);
    for (int i = 0; i < 120; i++) begin
      logic [3:0]  c;
      logic [31:0] va, vb;
      logic [4:0]  sh;
      c  = codes[$urandom_range(15, 0)];
      va = $urandom;
      vb = $urandom;
      case ($urandom_range(3, 0))
        0: va = vb;
        1: begin va = {va[31], 31'($urandom_range(3, 0))}; vb = {vb[31], 31'd0}; end
        default: ;
      endcase
      sh = ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0));
      if ($urandom_range(1, 0) == 1) va[4:0] = 5'($urandom_range(6, 0));
      run_op(c, va, vb, sh, bit'($urandom_range(1, 0)));
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    rv = 32'(n_fail);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
